// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR generator.
// Covers the mode encodings, a table of maximal feedback polynomials and the Fibonacci tap mapping.
package lfsr_pkg;

  localparam int LFSR_FIB = 0;
  localparam int LFSR_GAL = 1;

  localparam int LFSR_MIN_W = 3;
  localparam int LFSR_MAX_W = 32;

  // Maximal-length feedback polynomials, x^WIDTH term omitted (bit k = coeff of x^k).
  function automatic logic [31:0] default_poly(input int width);
    logic [31:0] p;
    p = 32'h0;
    case (width)
      3:       p = 32'h0000_0003;
      4:       p = 32'h0000_0003;
      5:       p = 32'h0000_0005;
      6:       p = 32'h0000_0003;
      7:       p = 32'h0000_0003;
      8:       p = 32'h0000_001D;
      9:       p = 32'h0000_0011;
      10:      p = 32'h0000_0009;
      11:      p = 32'h0000_0005;
      12:      p = 32'h0000_0053;
      13:      p = 32'h0000_001B;
      14:      p = 32'h0000_0443;
      15:      p = 32'h0000_0003;
      16:      p = 32'h0000_100B;
      17:      p = 32'h0000_0009;
      18:      p = 32'h0000_0081;
      19:      p = 32'h0000_0027;
      20:      p = 32'h0000_0009;
      21:      p = 32'h0000_0005;
      22:      p = 32'h0000_0003;
      23:      p = 32'h0000_0021;
      24:      p = 32'h0000_0087;
      25:      p = 32'h0000_0009;
      26:      p = 32'h0000_0047;
      27:      p = 32'h0000_0027;
      28:      p = 32'h0000_0009;
      29:      p = 32'h0000_0005;
      30:      p = 32'h0000_0053;
      31:      p = 32'h0000_0009;
      32:      p = 32'h0040_0007;
      default: p = 32'h0000_0003;
    endcase
    return p;
  endfunction

  // Fibonacci taps: coefficient of x^k drives state bit WIDTH-1-k.
  function automatic logic [31:0] fib_mask(input logic [31:0] poly, input int width);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < LFSR_MAX_W; k++) begin
      if (k < width) begin
        m[width-1-k] = poly[k];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-shift next-state function of an LFSR.
// The top chains several copies of this block to take multiple shifts per clock.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [31:0] POLY  = 32'h71,
  parameter int          MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_next
);

  localparam logic [31:0]      FMASK_FULL = fib_mask(POLY, WIDTH);
  localparam logic [WIDTH-1:0] FMASK      = FMASK_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS       = POLY[WIDTH-1:0];

  generate
    if (MODE == LFSR_GAL) begin : g_galois
      // Feedback from the outgoing MSB is folded into every tapped position.
      assign s_next = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
    end else begin : g_fibonacci
      assign s_next = {s[WIDTH-2:0], ^(s & FMASK)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with seed load, clock enable, zero-seed protection,
// period-wrap detection and a count of enabled cycles since the last seed or wrap.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [31:0] POLY  = 32'h71,
  parameter int          MODE  = LFSR_FIB,
  parameter int          STEPS = 1,
  parameter logic [31:0] SEED  = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] data,
  output logic             serial_out,
  output logic             wrap,
  output logic [WIDTH-1:0] seq_cnt,
  output logic             zero_fix
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_SEED = (SEED_W == '0) ? ONE : SEED_W;

  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] seed_reg, seed_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             wrap_reg, wrap_next;
  logic             zfix_reg, zfix_next;

  // chain[0] is the current state; chain[STEPS] is the state after a full enabled cycle.
  logic [WIDTH-1:0] chain [0:STEPS];
  logic [WIDTH-1:0] stepped;

  assign chain[0] = data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_step
      lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .MODE  (MODE)
      ) u_step (
        .s      (chain[gi]),
        .s_next (chain[gi+1])
      );
    end
  endgenerate

  assign stepped = chain[STEPS];

  // Load beats enable; a zero seed is replaced by one so the lock-up state is never entered.
  always_comb begin
    data_next = data_reg;
    seed_next = seed_reg;
    cnt_next  = cnt_reg;
    wrap_next = 1'b0;
    zfix_next = 1'b0;
    if (load) begin
      cnt_next = '0;
      if (seed_in == '0) begin
        data_next = ONE;
        seed_next = ONE;
        zfix_next = 1'b1;
      end else begin
        data_next = seed_in;
        seed_next = seed_in;
      end
    end else if (en) begin
      data_next = stepped;
      if (stepped == seed_reg) begin
        wrap_next = 1'b1;
        cnt_next  = '0;
      end else begin
        cnt_next = cnt_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RST_SEED;
      seed_reg <= RST_SEED;
      cnt_reg  <= '0;
      wrap_reg <= 1'b0;
      zfix_reg <= 1'b0;
    end else begin
      data_reg <= data_next;
      seed_reg <= seed_next;
      cnt_reg  <= cnt_next;
      wrap_reg <= wrap_next;
      zfix_reg <= zfix_next;
    end
  end

  assign data       = data_reg;
  assign serial_out = data_reg[WIDTH-1];
  assign wrap       = wrap_reg;
  assign seq_cnt    = cnt_reg;
  assign zero_fix   = zfix_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Galois x1, Fibonacci x1 and Galois x8 instances share stimulus.
// Expected values come from hand tables and a small independent 8-bit reference model.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed_in = 8'h00;

  logic [7:0] g1_data, f1_data, g8_data;
  logic [7:0] g1_cnt, f1_cnt, g8_cnt;
  logic       g1_ser, f1_ser, g8_ser;
  logic       g1_wrap, f1_wrap, g8_wrap;
  logic       g1_zf, f1_zf, g8_zf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .POLY(32'h71), .MODE(LFSR_GAL), .STEPS(1), .SEED(32'd1)) u_g1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .data(g1_data), .serial_out(g1_ser), .wrap(g1_wrap), .seq_cnt(g1_cnt), .zero_fix(g1_zf));

  lfsr_gen #(.WIDTH(8), .POLY(32'h71), .MODE(LFSR_FIB), .STEPS(1), .SEED(32'd1)) u_f1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .data(f1_data), .serial_out(f1_ser), .wrap(f1_wrap), .seq_cnt(f1_cnt), .zero_fix(f1_zf));

  lfsr_gen #(.WIDTH(8), .POLY(32'h71), .MODE(LFSR_GAL), .STEPS(8), .SEED(32'd1)) u_g8 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .data(g8_data), .serial_out(g8_ser), .wrap(g8_wrap), .seq_cnt(g8_cnt), .zero_fix(g8_zf));

  function automatic logic [7:0] gal(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
  endfunction

  function automatic logic [7:0] fib(input logic [7:0] s);
    return {s[6:0], ^(s & 8'h8E)};
  endfunction

  function automatic logic [7:0] gal8(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int j = 0; j < 8; j++) t = gal(t);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] gal_exp [0:9];
  logic [7:0] fib_exp [0:3];
  logic       seen [0:255];
  logic [7:0] mg, mf, m8, f_seed, exp_g, exp_f;
  int         fcnt;

  initial begin
    gal_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h71, 8'hE2, 8'hB5};
    fib_exp = '{8'h02, 8'h05, 8'h0B, 8'h16};
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_g1_data", g1_data, 8'h01);
    check("rst_f1_data", f1_data, 8'h01);
    check("rst_g8_data", g8_data, 8'h01);
    check("rst_g1_cnt", g1_cnt, 8'h00);
    check("rst_g1_wrap", g1_wrap, 1'b0);
    check("rst_g1_zf", g1_zf, 1'b0);
    check("rst_g1_ser", g1_ser, 1'b0);

    // Free run from reset for a full period
    reset = 1'b0;
    en = 1'b1;
    mg = 8'h01; mf = 8'h01; m8 = 8'h01; f_seed = 8'h01; fcnt = 0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      mg = gal(mg);
      mf = fib(mf);
      m8 = gal8(m8);
      exp_g = (i <= 10) ? gal_exp[i-1] : mg;
      exp_f = (i <= 4) ? fib_exp[i-1] : mf;
      if (mf == f_seed) fcnt = 0; else fcnt = fcnt + 1;
      check($sformatf("run_g1_data[%0d]", i), g1_data, exp_g);
      check($sformatf("run_g1_ser[%0d]", i), g1_ser, exp_g[7]);
      check($sformatf("run_g1_wrap[%0d]", i), g1_wrap, (i == 255));
      check($sformatf("run_g1_cnt[%0d]", i), g1_cnt, (i == 255) ? 0 : i);
      if (i < 255) begin
        check($sformatf("run_g1_repeat[%0d]", i), seen[g1_data], 1'b0);
        check($sformatf("run_g1_nonzero[%0d]", i), (g1_data != 8'h00), 1'b1);
        seen[g1_data] = 1'b1;
      end
      check($sformatf("run_f1_data[%0d]", i), f1_data, exp_f);
      check($sformatf("run_f1_wrap[%0d]", i), f1_wrap, (mf == f_seed));
      check($sformatf("run_f1_cnt[%0d]", i), f1_cnt, fcnt[7:0]);
      check($sformatf("run_g8_data[%0d]", i), g8_data, m8);
      check($sformatf("run_g8_wrap[%0d]", i), g8_wrap, (i == 255));
      check($sformatf("run_g8_cnt[%0d]", i), g8_cnt, (i == 255) ? 0 : i);
    end

    // Enable toggling: state holds while en is low
    en = 1'b0;
    tick();
    tick();
    check("hold_g1_data", g1_data, 8'h01);
    check("hold_g1_wrap", g1_wrap, 1'b0);
    check("hold_g1_cnt", g1_cnt, 8'h00);
    check("hold_f1_data", f1_data, mf);
    en = 1'b1;
    tick();
    check("tog1_g1_data", g1_data, 8'h02);
    check("tog1_g1_cnt", g1_cnt, 8'h01);
    tick();
    check("tog2_g1_data", g1_data, 8'h04);
    en = 1'b0;
    tick();
    check("tog3_g1_data", g1_data, 8'h04);
    check("tog3_g1_cnt", g1_cnt, 8'h02);
    check("tog3_g8_data", g8_data, gal8(gal8(8'h01)));

    // Zero seed is substituted with one
    load = 1'b1;
    seed_in = 8'h00;
    tick();
    check("ld0_g1_data", g1_data, 8'h01);
    check("ld0_g1_zf", g1_zf, 1'b1);
    check("ld0_g1_cnt", g1_cnt, 8'h00);
    check("ld0_f1_zf", f1_zf, 1'b1);
    check("ld0_g8_data", g8_data, 8'h01);
    load = 1'b0;
    tick();
    check("ld0b_g1_zf", g1_zf, 1'b0);
    check("ld0b_g1_data", g1_data, 8'h01);

    // Load together with enable: load wins, no step taken
    load = 1'b1;
    en = 1'b1;
    seed_in = 8'h5A;
    tick();
    check("ld5a_g1_data", g1_data, 8'h5A);
    check("ld5a_f1_data", f1_data, 8'h5A);
    check("ld5a_g8_data", g8_data, 8'h5A);
    check("ld5a_g1_cnt", g1_cnt, 8'h00);
    check("ld5a_g1_zf", g1_zf, 1'b0);
    check("ld5a_g1_wrap", g1_wrap, 1'b0);

    // Full period from the loaded seed; wrap must track the new active seed
    load = 1'b0;
    mg = 8'h5A; m8 = 8'h5A;
    for (int i = 1; i <= 255; i++) begin
      tick();
      mg = gal(mg);
      m8 = gal8(m8);
      if (i == 1) begin
        check("seed_g1_first", g1_data, 8'hB4);
        check("seed_f1_first", f1_data, 8'hB4);
      end
      check($sformatf("seed_g1_data[%0d]", i), g1_data, mg);
      check($sformatf("seed_g1_wrap[%0d]", i), g1_wrap, (i == 255));
      check($sformatf("seed_g1_cnt[%0d]", i), g1_cnt, (i == 255) ? 0 : i);
      check($sformatf("seed_g8_data[%0d]", i), g8_data, m8);
      check($sformatf("seed_g8_wrap[%0d]", i), g8_wrap, (i == 255));
    end
    check("seed_g1_back", g1_data, 8'h5A);

    // Reset mid-run with enable still high
    tick();
    reset = 1'b1;
    tick();
    check("mrst_g1_data", g1_data, 8'h01);
    check("mrst_g1_cnt", g1_cnt, 8'h00);
    check("mrst_g1_wrap", g1_wrap, 1'b0);
    check("mrst_g8_data", g8_data, 8'h01);
    check("mrst_f1_data", f1_data, 8'h01);
    reset = 1'b0;
    tick();
    check("mrst_next_g1_data", g1_data, 8'h02);
    check("mrst_next_g1_cnt", g1_cnt, 8'h01);
    check("mrst_next_f1_data", f1_data, 8'h02);
    check("mrst_next_g8_data", g8_data, gal8(8'h01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
